midi_msg_rx: RTL and testbench
==============================

MIDI_MSG_RX -- requirements
Module: midi_msg_rx

Interface
REQ-001 SHALL have parameter BAUD_CNT, default 3200, clk cycles per MIDI bit (31250 baud at 100 MHz); even, >= 8.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port midi_rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port msg_valid  output  1  one-cycle pulse; complete message on msg_* this cycle.
REQ-006 SHALL have port msg_status  output  8  status byte of the message.
REQ-007 SHALL have port msg_data1  output  8  first data byte; 0 if absent.
REQ-008 SHALL have port msg_data2  output  8  second data byte; 0 if absent.
REQ-009 SHALL have port msg_len  output  2  total bytes in message, 1..3.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port busy  output  1  high while the byte receiver is not IDLE.

Function
REQ-012 SHALL pass midi_rx through a 2-flop synchronizer; all logic uses the synchronized value (rx_s).
REQ-013 SHALL run a byte receiver FSM: IDLE, START, DATA, STOP, WAIT_HI.
REQ-014 IDLE: 1->0 transition on rx_s SHALL enter START with bit counter cleared.
REQ-015 START: after BAUD_CNT/2 cycles, rx_s=0 -> DATA; rx_s=1 -> IDLE as a glitch, no output.
REQ-016 DATA: SHALL sample rx_s every BAUD_CNT cycles, 8 samples, LSB first, then enter STOP.
REQ-017 STOP: after BAUD_CNT cycles, rx_s=1 -> byte accepted, IDLE; rx_s=0 -> frame_err pulse, byte discarded, parser partial message dropped, WAIT_HI.
REQ-018 WAIT_HI: SHALL stay until rx_s=1, then IDLE; no start detection while low.
REQ-019 Parser SHALL hold running status rs (8 bits, 0 = none), expected data count need, and data count got.
REQ-020 Byte 0x80-0xEF: rs=byte, got=0; need=1 for high nibble C/D, else need=2; any partial message is discarded.
REQ-021 Byte 0xF0-0xF7: SHALL clear rs and discard partial message; no output. SysEx payload is ignored.
REQ-022 Byte 0xF8-0xFF (realtime): SHALL emit msg_len=1, msg_status=byte, data 0; rs, got and held data unchanged.
REQ-023 Data byte (0x00-0x7F) with rs=0: SHALL discard it.
REQ-024 Data byte with rs!=0: store as data1 (got=0) or data2 (got=1). When got reaches need, emit msg_status=rs, msg_len=need+1, unused data=0, then got=0 and rs kept (running status).
REQ-025 msg_valid SHALL assert exactly one cycle, the cycle after the accepting stop-bit sample. msg_* SHALL hold until the next msg_valid.
REQ-026 At most one message per received byte. No backpressure: the consumer samples on msg_valid.
REQ-027 Counters SHALL be sized ceil(log2(BAUD_CNT)) bits and never wrap within a bit period.

Reset
REQ-028 rst SHALL force: FSM IDLE, synchronizer flops 1, rs=0, got=0, need=0, msg_valid=0, frame_err=0, busy=0, msg_status/data1/data2=0, msg_len=0.
REQ-029 rst mid-byte or mid-message SHALL discard all partial state. The next start is detected only after rx_s is seen high.

Verification (BAUD_CNT=16)
REQ-030 Send 0xB0,0x2E,0x7F at 16 clk/bit -> one msg_valid: status B0, data1 2E, data2 7F, len 3, one cycle after third stop sample.
REQ-031 Running status: 0x90,0x3C,0x40 then 0x3C,0x00 -> two pulses, both status 90, second data 3C/00, len 3.
REQ-032 0xC5,0x07 -> status C5, data1 07, data2 00, len 2. Then 0xF8 inserted between 0x90 and 0x3C of a note-on -> F8 len 1 pulse, then the 90/3C/40 message intact.
REQ-033 Byte 0x55 with stop bit low -> frame_err one cycle, no msg_valid, busy until line high. Next valid 0xB0,0x01,0x02 decoded correctly.
REQ-034 6-cycle low glitch on idle line -> no byte, no pulse. Data 0x12 after reset with rs=0 -> discarded. rst asserted mid-data-bit -> all outputs 0 next cycle.

Source files
------------

// File: rtl/midi_msg_rx.sv
// MIDI serial receiver with a running-status message parser.
// Turns 8N1 bytes on midi_rx into complete 1..3 byte channel/realtime messages.
module midi_msg_rx #(
  parameter int BAUD_CNT = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [7:0] msg_data1,
  output logic [7:0] msg_data2,
  output logic [1:0] msg_len,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_CNT);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CNT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_CNT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t        state, state_n;
  logic          rx_meta, rx_s, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          half_done, full_done, byte_ok, frame_bad;

  logic [7:0]    rs, hold_d1;
  logic [1:0]    need;
  logic          got;

  assign half_done = (cnt == HALF_LAST);
  assign full_done = (cnt == FULL_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= midi_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_comb begin
    state_n   = state;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE:    if (rx_prev && !rx_s) state_n = START;
      START:   if (half_done) state_n = rx_s ? IDLE : DATA;
      DATA:    if (full_done && bit_cnt == 3'd7) state_n = STOP;
      STOP: begin
        if (full_done) begin
          if (rx_s) begin
            byte_ok = 1'b1;
            state_n = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_n   = WAIT_HI;
          end
        end
      end
      WAIT_HI: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bit timing: cnt restarts at every sample point so it never wraps mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state <= state_n;
      case (state)
        START: cnt <= half_done ? '0 : cnt + 1'b1;
        DATA: begin
          if (full_done) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: cnt <= full_done ? '0 : cnt + 1'b1;
        default: begin
          cnt     <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Parser acts on the same edge as the accepting stop sample, so msg_valid
  // is high during the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_valid  <= 1'b0;
      frame_err  <= 1'b0;
      msg_status <= '0;
      msg_data1  <= '0;
      msg_data2  <= '0;
      msg_len    <= '0;
      rs         <= '0;
      hold_d1    <= '0;
      need       <= '0;
      got        <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      frame_err <= frame_bad;
      if (frame_bad) got <= 1'b0;
      if (byte_ok) begin
        if (shift >= 8'hF8) begin
          msg_valid  <= 1'b1;
          msg_status <= shift;
          msg_data1  <= 8'h00;
          msg_data2  <= 8'h00;
          msg_len    <= 2'd1;
        end else if (shift >= 8'hF0) begin
          rs  <= 8'h00;
          got <= 1'b0;
        end else if (shift[7]) begin
          rs   <= shift;
          got  <= 1'b0;
          need <= (shift[7:5] == 3'b110) ? 2'd1 : 2'd2;
        end else if (rs != 8'h00) begin
          if (!got) begin
            hold_d1 <= shift;
            if (need == 2'd1) begin
              msg_valid  <= 1'b1;
              msg_status <= rs;
              msg_data1  <= shift;
              msg_data2  <= 8'h00;
              msg_len    <= 2'd2;
            end else begin
              got <= 1'b1;
            end
          end else begin
            msg_valid  <= 1'b1;
            msg_status <= rs;
            msg_data1  <= hold_d1;
            msg_data2  <= shift;
            msg_len    <= 2'd3;
            got        <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_rx.sv
// Scoreboard bench for midi_msg_rx: directed MIDI sequences followed by random
// bytes, glitches and framing errors, checked against a queue-based message model.
module tb_midi_msg_rx;

  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       midi_rx;
  logic       msg_valid;
  logic [7:0] msg_status, msg_data1, msg_data2;
  logic [1:0] msg_len;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  midi_msg_rx #(.BAUD_CNT(BAUD)) dut (
    .clk        (clk),
    .rst        (rst),
    .midi_rx    (midi_rx),
    .msg_valid  (msg_valid),
    .msg_status (msg_status),
    .msg_data1  (msg_data1),
    .msg_data2  (msg_data2),
    .msg_len    (msg_len),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] len;
  } msg_t;

  msg_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_frames = 0;
  int         ncyc = 0;
  int         stop_start = 0;
  logic       prev_valid = 1'b0;

  // Reference model state: running status, message length, collected data bytes.
  logic [7:0] m_rs = 8'h00;
  int         m_need = 0;
  logic [7:0] m_pend[$];

  logic [7:0] dir_seq [14] = '{8'hB0, 8'h2E, 8'h7F,
                               8'h90, 8'h3C, 8'h40, 8'h3C, 8'h00,
                               8'hC5, 8'h07,
                               8'h90, 8'hF8, 8'h3C, 8'h40};

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Message-level model of the running-status rules.
  function automatic void model_byte(input logic [7:0] b);
    msg_t m;
    if (b >= 8'hF8) begin
      m = '{st: b, d1: 8'h00, d2: 8'h00, len: 2'd1};
      exp_q.push_back(m);
    end else if (b >= 8'hF0) begin
      m_rs = 8'h00;
      m_pend.delete();
    end else if (b >= 8'h80) begin
      m_rs   = b;
      m_pend.delete();
      m_need = (b[7:4] == 4'hC || b[7:4] == 4'hD) ? 1 : 2;
    end else if (m_rs != 8'h00) begin
      m_pend.push_back(b);
      if (m_pend.size() == m_need) begin
        m = '{st: m_rs, d1: m_pend[0], d2: 8'h00, len: 2'(m_need + 1)};
        if (m_need == 2) m.d2 = m_pend[1];
        exp_q.push_back(m);
        m_pend.delete();
      end
    end
  endfunction

  task automatic hold(input logic v, input int n);
    midi_rx = v;
    repeat (n) @(posedge clk);
  endtask

  // Sends one 8N1 frame; stop_ok=0 drives a low stop bit and then keeps the
  // line low for a while before releasing it.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input int gap);
    hold(1'b0, BAUD);
    for (int i = 0; i < 8; i++) hold(b[i], BAUD);
    if (stop_ok) model_byte(b);
    else begin
      exp_frames++;
      m_pend.delete();
    end
    stop_start = ncyc;
    if (stop_ok) begin
      hold(1'b1, BAUD + gap);
    end else begin
      hold(1'b0, BAUD + 24);
      @(negedge clk);
      checkOutput("busy_while_line_low", int'(busy), 1);
      @(posedge clk);
      hold(1'b1, 20);
      @(negedge clk);
      checkOutput("busy_after_line_high", int'(busy), 0);
      @(posedge clk);
    end
  endtask

  task automatic glitch(input int n);
    hold(1'b0, n);
    hold(1'b1, 20);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_msg_valid"},  int'(msg_valid), 0);
    checkOutput({tag, "_frame_err"},  int'(frame_err), 0);
    checkOutput({tag, "_busy"},       int'(busy), 0);
    checkOutput({tag, "_msg_status"}, int'(msg_status), 0);
    checkOutput({tag, "_msg_data1"},  int'(msg_data1), 0);
    checkOutput({tag, "_msg_data2"},  int'(msg_data2), 0);
    checkOutput({tag, "_msg_len"},    int'(msg_len), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a message.
  always @(negedge clk) begin
    msg_t e;
    int   dt;
    if (msg_valid) begin
      checkOutput("msg_valid_single_cycle", int'(prev_valid), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_msg: got status 0x%0h len %0d, expected no message",
                 msg_status, msg_len);
      end else begin
        e = exp_q.pop_front();
        checkOutput("msg_status", int'(msg_status), int'(e.st));
        checkOutput("msg_data1",  int'(msg_data1),  int'(e.d1));
        checkOutput("msg_data2",  int'(msg_data2),  int'(e.d2));
        checkOutput("msg_len",    int'(msg_len),    int'(e.len));
        dt = ncyc - stop_start;
        checkOutput("msg_within_stop_bit", int'(dt >= 8 && dt <= 16), 1);
      end
    end
    if (frame_err) begin
      checkOutput("frame_err_expected", int'(exp_frames > 0), 1);
      if (exp_frames > 0) exp_frames--;
    end
    prev_valid = msg_valid;
    ncyc++;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    int gap;
    rst     = 1'b1;
    midi_rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    rst = 1'b0;
    hold(1'b1, 20);

    // Short glitch, then a data byte with no running status: both ignored.
    glitch(6);
    applyStimulus(8'h12, 1'b1, 5);

    // Control change, running-status note-ons, program change, realtime insert.
    for (int i = 0; i < 14; i++) applyStimulus(dir_seq[i], 1'b1, 3);

    // Framing error then a clean control change.
    applyStimulus(8'h55, 1'b0, 0);
    applyStimulus(8'hB0, 1'b1, 2);
    applyStimulus(8'h01, 1'b1, 2);
    applyStimulus(8'h02, 1'b1, 2);

    // Reset in the middle of a data bit clears everything, including running status.
    applyStimulus(8'h90, 1'b1, 2);
    hold(1'b0, BAUD);
    hold(1'b1, BAUD);
    hold(1'b0, BAUD);
    hold(1'b1, BAUD / 2);
    rst     = 1'b1;
    midi_rx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_byte_reset");
    @(posedge clk);
    rst  = 1'b0;
    m_rs = 8'h00;
    m_pend.delete();
    hold(1'b1, 20);
    applyStimulus(8'h11, 1'b1, 2);

    // Random mix of data, status, realtime, sysex, framing errors and glitches.
    for (int n = 0; n < 80; n++) begin
      r   = $urandom_range(0, 99);
      gap = $urandom_range(0, 6);
      if (r < 50)      applyStimulus(8'($urandom_range(0, 127)), 1'b1, gap);
      else if (r < 72) applyStimulus(8'($urandom_range(128, 239)), 1'b1, gap);
      else if (r < 82) applyStimulus(8'($urandom_range(248, 255)), 1'b1, gap);
      else if (r < 88) applyStimulus(8'($urandom_range(240, 247)), 1'b1, gap);
      else if (r < 93) applyStimulus(8'($urandom_range(0, 255)), 1'b0, 0);
      else             glitch($urandom_range(1, 6));
    end

    hold(1'b1, 60);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    checkOutput("frame_errs_drained", exp_frames, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
